// File: rtl/acquisition_buffer.sv
// Circular acquisition memory: fills a pre-trigger history, waits for a trigger,
// completes the post-trigger window, then streams the whole window oldest-first.
module acquisition_buffer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] pretrigger,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  triggered,
    input  logic                  force_trigger,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  armed,
    output logic                  done
);

    localparam int N = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH    = (ADDR_WIDTH+1)'(N);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   LAST_IDX = DEPTH - CNT_ONE;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_FILL = 3'd1,
        ARMED    = 3'd2,
        POST     = 3'd3,
        READOUT  = 3'd4
    } state_t;

    logic [DATA_WIDTH-1:0] mem [N];

    state_t                stateQ, stateD;
    logic [ADDR_WIDTH-1:0] preQ, preD;
    logic [ADDR_WIDTH-1:0] wrPtrQ, wrPtrD;
    logic [ADDR_WIDTH-1:0] rdPtrQ, rdPtrD;
    logic [ADDR_WIDTH:0]   cntQ, cntD;
    logic                  rdValidQ, rdValidD;
    logic [DATA_WIDTH-1:0] rdDataQ, rdDataD;
    logic                  rdLastQ, rdLastD;
    logic                  busyQ, armedQ, doneQ, doneD;
    logic                  wrEn;
    logic                  trig;
    logic [ADDR_WIDTH:0]   postLoad;

    // One counter serves three roles: pre-fill count, post-trigger countdown,
    // and number of words loaded into the readout register.
    always_comb begin
        stateD   = stateQ;
        preD     = preQ;
        wrPtrD   = wrPtrQ;
        rdPtrD   = rdPtrQ;
        cntD     = cntQ;
        rdValidD = rdValidQ;
        rdDataD  = rdDataQ;
        rdLastD  = rdLastQ;
        doneD    = 1'b0;
        wrEn     = 1'b0;
        trig     = triggered | force_trigger;
        postLoad = DEPTH - {1'b0, preQ};

        case (stateQ)
            IDLE: begin
                if (start) begin
                    preD   = pretrigger;
                    wrPtrD = '0;
                    rdPtrD = '0;
                    cntD   = '0;
                    stateD = (pretrigger == '0) ? ARMED : PRE_FILL;
                end
            end
            PRE_FILL: begin
                wrEn = sample_valid;
                if (sample_valid) begin
                    cntD = cntQ + CNT_ONE;
                    if (cntQ + CNT_ONE == {1'b0, preQ}) stateD = ARMED;
                end
            end
            ARMED: begin
                wrEn = sample_valid;
                if (trig) begin
                    if (!sample_valid) begin
                        cntD   = postLoad;
                        stateD = POST;
                    end else if (postLoad == CNT_ONE) begin
                        cntD   = '0;
                        rdPtrD = wrPtrQ + PTR_ONE;
                        stateD = READOUT;
                    end else begin
                        cntD   = postLoad - CNT_ONE;
                        stateD = POST;
                    end
                end
            end
            POST: begin
                wrEn = sample_valid;
                if (sample_valid) begin
                    if (cntQ == CNT_ONE) begin
                        cntD   = '0;
                        rdPtrD = wrPtrQ + PTR_ONE;
                        stateD = READOUT;
                    end else begin
                        cntD = cntQ - CNT_ONE;
                    end
                end
            end
            READOUT: begin
                // The output register doubles as the synchronous memory read stage.
                if (rdValidQ && rd_ready && rdLastQ) begin
                    rdValidD = 1'b0;
                    rdLastD  = 1'b0;
                    doneD    = 1'b1;
                    stateD   = IDLE;
                end else if (!rdValidQ || rd_ready) begin
                    rdDataD  = mem[rdPtrQ];
                    rdPtrD   = rdPtrQ + PTR_ONE;
                    rdValidD = 1'b1;
                    rdLastD  = (cntQ == LAST_IDX);
                    cntD     = cntQ + CNT_ONE;
                end
            end
            default: stateD = IDLE;
        endcase

        if (wrEn) wrPtrD = wrPtrQ + PTR_ONE;
    end

    // Sample storage has no reset so a reset never disturbs captured data.
    always_ff @(posedge clk) begin
        if (wrEn) mem[wrPtrQ] <= sample;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= IDLE;
            preQ     <= '0;
            wrPtrQ   <= '0;
            rdPtrQ   <= '0;
            cntQ     <= '0;
            rdValidQ <= 1'b0;
            rdDataQ  <= '0;
            rdLastQ  <= 1'b0;
            busyQ    <= 1'b0;
            armedQ   <= 1'b0;
            doneQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            preQ     <= preD;
            wrPtrQ   <= wrPtrD;
            rdPtrQ   <= rdPtrD;
            cntQ     <= cntD;
            rdValidQ <= rdValidD;
            rdDataQ  <= rdDataD;
            rdLastQ  <= rdLastD;
            busyQ    <= (stateD != IDLE);
            armedQ   <= (stateD == ARMED);
            doneQ    <= doneD;
        end
    end

    assign rd_valid = rdValidQ;
    assign rd_data  = rdDataQ;
    assign rd_last  = rdLastQ;
    assign busy     = busyQ;
    assign armed    = armedQ;
    assign done     = doneQ;

endmodule

// File: doc/acquisition_buffer.md
# acquisition_buffer

Circular sample memory that consumes the one-clock trigger pulse from the trigger detection block and captures one acquisition per arm request. The acquisition is a fixed-size window of samples: a programmable number of samples before the trigger, with the rest taken after it. Once the window is complete, the block streams it out oldest-first over a valid/ready interface to the host-link side. It sits between the ADC sample path (after trigger-source selection) and the readout/transfer logic.

## Interface
- ADDR_WIDTH, 8, memory address width; depth N = 2^ADDR_WIDTH samples.
- DATA_WIDTH, 8, sample width.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  arm request pulse; honoured only in IDLE.
- pretrigger  in  ADDR_WIDTH  number of pre-trigger samples P (0..N-1); latched on accepted start.
- sample_valid  in  1  sample qualifier (decimated sample strobe).
- sample  in  DATA_WIDTH  input sample.
- triggered  in  1  one-clock trigger pulse from the detector.
- force_trigger  in  1  software trigger; identical effect to triggered.
- rd_ready  in  1  consumer ready.
- rd_valid  out  1  rd_data valid.
- rd_data  out  DATA_WIDTH  readout sample.
- rd_last  out  1  marks the N-th (final) readout word.
- busy  out  1  high in every state except IDLE.
- armed  out  1  high in ARMED only.
- done  out  1  one-clock pulse after the final readout transfer.

## Operation
- States: IDLE, PRE_FILL, ARMED, POST, READOUT. Unlisted encodings go to IDLE.
- IDLE:
  - start=1 latches P, clears wr_ptr and counters, and goes to PRE_FILL.
  - start is ignored in all other states.
- Write rule (PRE_FILL, ARMED, POST): each cycle with sample_valid=1 writes sample at wr_ptr, then increments wr_ptr modulo N. Cycles with sample_valid=0 write nothing.
- PRE_FILL:
  - Counts written samples.
  - Goes to ARMED on the edge where the count reaches P. P=0 goes to ARMED on the first clock, with no write required.
  - Trigger inputs are ignored in PRE_FILL, so P valid pre-trigger samples always exist.
- ARMED:
  - Keeps writing circularly, overwriting the oldest samples.
  - When (triggered | force_trigger)=1, goes to POST with the post counter loaded to N-P.
  - If sample_valid=1 in that same cycle, that sample is the first post-trigger sample and decrements the counter. Otherwise the next valid sample is the first.
- POST:
  - Each valid write decrements the counter.
  - The write that brings the counter to 0 moves to READOUT, with rd_ptr = the wrapped wr_ptr after that write (the oldest stored sample).
  - Trigger inputs are ignored in POST.
- READOUT:
  - Presents N words in order from rd_ptr, wrapping modulo N.
  - Readout word index P is the first post-trigger sample.
  - A transfer occurs on any cycle with rd_valid=1 and rd_ready=1.
  - Sample inputs and trigger inputs are ignored.
- After the transfer with rd_last=1: done pulses for one clock, state returns to IDLE, rd_valid drops.
- Counters are ADDR_WIDTH+1 bits wide so that N-P is representable. Pointers are ADDR_WIDTH bits and wrap naturally.
- Reset in any state:
  - Returns to IDLE.
  - Pointers and counters are cleared.
  - Memory contents are not cleared.

## Timing
- Reset values: rd_valid=0, rd_last=0, rd_data=0, busy=0, armed=0, done=0.
- All outputs are registered.
- start accepted on edge k gives busy=1 from cycle k+1.
- armed rises the cycle after the P-th valid sample is written (P=0: the cycle after start is accepted).
- Trigger to POST: one edge. The trigger pulse needs no hold.
- READOUT entry to first rd_valid: at most 2 cycles (synchronous memory read).
- Throughput: one word per clock while rd_ready=1.
- While rd_valid=1 and rd_ready=0, rd_data and rd_last hold stable.
- done is asserted the cycle after the final transfer, coincident with busy=0.
- Total readout transfers per acquisition: exactly N.

## Test plan
- Baseline capture (N=16, P=4, ramp 0,1,2,... valid every cycle):
  - Stimulus: trigger pulse in the cycle sample 20 is written.
  - Required: readout 16..31, word index 4 = 20, rd_last on 31, done one cycle after the last transfer.
- Zero pre-trigger (P=0): trigger with sample 5 -> readout 5..20 and armed=1 the cycle after start.
- Early trigger ignored (P=8):
  - Stimulus: trigger at sample 3 (PRE_FILL), then trigger at sample 12.
  - Required: readout 4..19; a force_trigger pulse in POST has no effect.
- Gapped samples (sample_valid every other cycle):
  - Stimulus: trigger in a cycle with sample_valid=0.
  - Required: the next valid sample appears at word index P.
- Backpressure: rd_ready high one cycle in three -> rd_data stable during stalls, 16 transfers in order, no duplicates or drops.
- Reset mid-POST:
  - Stimulus: assert reset mid-POST.
  - Required: busy=0 and rd_valid=0 immediately; a new start then completes a correct capture.
